spice_node_relax: RTL

SPICE_NODE_RELAX -- requirements
Module: spice_node_relax

---
 rtl/spice_node_relax.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spice_node_relax.sv
// +----------------------------------------------------------------------------+
// | Module   : spice_node_relax                                                |
// | Purpose  : Iterative relaxation of one circuit node. Each RUN cycle sums   |
// |            N signed branch currents, scales them by the node capacitance   |
// |            (arithmetic shift) and integrates into a saturating voltage.    |
// |            A hysteretic comparator turns the voltage into a digital level. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module spice_node_relax #(
  parameter int              W         = 16,
  parameter int              N         = 4,
  parameter int              CAP_SHIFT = 2,
  parameter int              MAX_ITER  = 64,
  parameter int              EPS       = 4,
  parameter logic [W-1:0]    VHI       = 16'h3FFF,
  parameter logic [W-1:0]    VLO       = 16'hC000,
  parameter logic [W-1:0]    TH_HI     = 16'h1000,
  parameter logic [W-1:0]    TH_LO     = 16'hF000
) (
  input  logic                          eclk,
  input  logic                          ereset_n,
  input  logic                          start,
  input  logic [N*W-1:0]                i_in,
  input  logic                          load,
  input  logic [W-1:0]                  load_v,
  output logic [W-1:0]                  v,
  output logic                          p,
  output logic                          busy,
  output logic                          done,
  output logic                          settled,
  output logic [$clog2(MAX_ITER+1)-1:0] iter
);

  // Sum width leaves room for N full-scale channels plus one guard bit.
  localparam int SW = W + $clog2(N) + 1;
  localparam int IW = $clog2(MAX_ITER+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Rails and thresholds widened so all comparisons are exact signed ones.
  localparam logic signed [SW:0]   c_vhi_ext = {{(SW+1-W){VHI[W-1]}}, VHI};
  localparam logic signed [SW:0]   c_vlo_ext = {{(SW+1-W){VLO[W-1]}}, VLO};
  localparam logic signed [SW-1:0] c_eps_pos = SW'(EPS);
  localparam logic signed [SW-1:0] c_eps_neg = SW'(-EPS);
  localparam logic [IW-1:0]        c_max_it  = IW'(MAX_ITER);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [W-1:0]        r_v;
  logic                r_p;
  logic                r_settled;
  logic [IW-1:0]       r_iter;
  logic [1:0]          r_cnt;

  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_step;
  logic signed [SW:0]   w_vsum;
  logic [W-1:0]         w_vsat;
  logic                 w_small;
  logic [1:0]           w_cnt_nxt;
  logic [IW-1:0]        w_iter_nxt;
  logic                 w_hit_settle;
  logic                 w_hit_max;
  logic                 w_go;

  // Sign-extend every channel and accumulate the total node current.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = w_sum + {{(SW-W){i_in[k*W+W-1]}}, i_in[k*W +: W]};
    end
  end

  // Integrate the scaled current and clamp to the rails.
  always_comb begin
    w_step  = w_sum >>> CAP_SHIFT;
    w_vsum  = {{(SW+1-W){r_v[W-1]}}, r_v} + {w_step[SW-1], w_step};
    if (w_vsum > c_vhi_ext) begin
      w_vsat = VHI;
    end else if (w_vsum < c_vlo_ext) begin
      w_vsat = VLO;
    end else begin
      w_vsat = w_vsum[W-1:0];
    end
  end

  // Settle detection and termination conditions for the current RUN cycle.
  always_comb begin
    w_small      = (w_sum <= c_eps_pos) && (w_sum >= c_eps_neg);
    w_go         = (r_state == S_IDLE) && start;
    if (load) begin
      w_cnt_nxt = 2'd0;
    end else if (w_small) begin
      w_cnt_nxt = r_cnt + 2'd1;
    end else begin
      w_cnt_nxt = 2'd0;
    end
    w_iter_nxt   = r_iter + {{(IW-1){1'b0}}, 1'b1};
    w_hit_settle = (w_cnt_nxt == 2'd2);
    w_hit_max    = (w_iter_nxt == c_max_it);
  end

  // State register.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: DONE always lasts a single cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_hit_settle || w_hit_max) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Node voltage, iteration count, settle count and settled flag.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      r_v       <= '0;
      r_iter    <= '0;
      r_cnt     <= 2'd0;
      r_settled <= 1'b0;
    end else begin
      if (load) begin
        r_v <= load_v;
      end else if (r_state == S_RUN) begin
        r_v <= w_vsat;
      end

      if (w_go) begin
        r_iter <= '0;
      end else if (r_state == S_RUN) begin
        r_iter <= w_iter_nxt;
      end

      if (w_go || load) begin
        r_cnt <= 2'd0;
      end else if (r_state == S_RUN) begin
        r_cnt <= w_cnt_nxt;
      end

      if (w_go) begin
        r_settled <= 1'b0;
      end else if ((r_state == S_RUN) && w_hit_settle) begin
        r_settled <= 1'b1;
      end
    end
  end

  // Hysteretic level detector driven from the registered voltage.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      r_p <= 1'b0;
    end else if ($signed(r_v) >= $signed(TH_HI)) begin
      r_p <= 1'b1;
    end else if ($signed(r_v) <= $signed(TH_LO)) begin
      r_p <= 1'b0;
    end
  end

  assign v       = r_v;
  assign p       = r_p;
  assign settled = r_settled;
  assign iter    = r_iter;

endmodule

`default_nettype wire
